// File: rtl/layer2_pkg.sv
// Layer-2 constants and shared types for the 2x2 max-pool stage.
// Holds image/channel dimensions, pooled dimensions and the row-FSM state enum.
// Imported by maxpool2, maxpool2_if users and pool_line_buf.
package layer2_pkg;

    localparam int IMAGE_WIDTH  = 13;
    localparam int IMAGE_HEIGHT = 17;
    localparam int CHANNELS     = 64;
    localparam int DATA_BITS    = 32;

    // Odd trailing column/row are dropped, so the pooled frame is floor(W/2) x floor(H/2).
    localparam int POOL_WIDTH   = IMAGE_WIDTH / 2;
    localparam int POOL_HEIGHT  = IMAGE_HEIGHT / 2;

    typedef enum logic [1:0] {
        ROW_EVEN = 2'd0,   // first row of a pooling pair
        ROW_ODD  = 2'd1,   // second row of a pooling pair, produces outputs
        ROW_SKIP = 2'd2    // unpaired last row of an odd-height frame
    } row_state_t;

endpackage

// File: rtl/maxpool2_if.sv
// Pixel stream bundle for maxpool2: input pixel stream and pooled output stream.
// Signals: valid_in/data_in (into the pool), valid_out/data_out (out of the pool),
// frame_done (only when MAXPOOL2_FRAME_DONE_EN is defined). master = source/sink side, slave = pool side.
interface maxpool2_if #(
    parameter int CHANNELS  = layer2_pkg::CHANNELS,
    parameter int DATA_BITS = layer2_pkg::DATA_BITS
);
    logic                                  valid_in;
    logic [0:CHANNELS-1][DATA_BITS-1:0]    data_in;
    logic                                  valid_out;
    logic [0:CHANNELS-1][DATA_BITS-1:0]    data_out;
`ifdef MAXPOOL2_FRAME_DONE_EN
    logic                                  frame_done;

    modport master (output valid_in, output data_in,
                    input  valid_out, input data_out, input frame_done);
    modport slave  (input  valid_in, input data_in,
                    output valid_out, output data_out, output frame_done);
`else
    modport master (output valid_in, output data_in,
                    input  valid_out, input data_out);
    modport slave  (input  valid_in, input data_in,
                    output valid_out, output data_out);
`endif
endinterface

// File: rtl/maxpool2_line_buf.sv
// pool_line_buf: one-row buffer of horizontal pair maxima, DEPTH words of CHANNELS x DATA_BITS.
// Latency: write lands on the clock edge; read is combinational from rd_addr.
// Backpressure: none. Ports: clk, wr_en/wr_addr/wr_data (write), rd_addr/rd_data (read). No reset:
// every slot is rewritten during the even row before the odd row reads it.
module pool_line_buf #(
    parameter int DEPTH     = layer2_pkg::POOL_WIDTH,
    parameter int CHANNELS  = layer2_pkg::CHANNELS,
    parameter int DATA_BITS = layer2_pkg::DATA_BITS,
    parameter int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                               clk,
    input  logic                               wr_en,
    input  logic [AW-1:0]                      wr_addr,
    input  logic [0:CHANNELS-1][DATA_BITS-1:0] wr_data,
    input  logic [AW-1:0]                      rd_addr,
    output logic [0:CHANNELS-1][DATA_BITS-1:0] rd_data
);

    logic [0:CHANNELS-1][DATA_BITS-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxpool2.sv
// maxpool2: 2x2 stride-2 signed max pooling per channel over a raster pixel stream.
// Latency: 1 cycle from the odd-column pixel of an odd row to valid_out/data_out.
// Backpressure: none; every valid_in pixel is consumed, idle cycles freeze all state.
// Ports: clk, rst (async active-high), bus (maxpool2_if.slave: valid_in, data_in, valid_out,
// data_out, frame_done). Optional macro MAXPOOL2_FRAME_DONE_EN adds the frame_done pulse.
module maxpool2 #(
    parameter int IMAGE_WIDTH  = layer2_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = layer2_pkg::IMAGE_HEIGHT,
    parameter int CHANNELS     = layer2_pkg::CHANNELS,
    parameter int DATA_BITS    = layer2_pkg::DATA_BITS
) (
    input  logic      clk,
    input  logic      rst,
    maxpool2_if.slave bus
);
    import layer2_pkg::*;

    localparam int  POOL_W = IMAGE_WIDTH / 2;
    localparam int  POOL_H = IMAGE_HEIGHT / 2;
    localparam int  CW     = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int  RW     = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int  AW     = (POOL_W > 1) ? $clog2(POOL_W) : 1;
    localparam bit  H_ODD  = (IMAGE_HEIGHT % 2) == 1;

    typedef logic [0:CHANNELS-1][DATA_BITS-1:0] pix_t;

    // Per-channel signed max; on a tie the earlier-arriving operand wins.
    function automatic pix_t pix_max(input pix_t earlier, input pix_t later);
        pix_t res;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            res[ch] = ($signed(later[ch]) > $signed(earlier[ch])) ? later[ch] : earlier[ch];
        end
        return res;
    endfunction

    row_state_t     state, state_nxt;
    logic [CW-1:0]  col, col_nxt;
    logic [RW-1:0]  row, row_nxt;
    pix_t           hold;
    pix_t           lb_rd;
    pix_t           pair_max;
    pix_t           quad_max;
    logic [AW-1:0]  lb_addr;
    logic           col_last;
    logic           row_last;
    logic           hold_ld;
    logic           lb_wr;
    logic           out_fire;
    logic           frame_last;

    always_comb begin
        state_nxt  = state;
        col_nxt    = col;
        row_nxt    = row;
        col_last   = (col == CW'(IMAGE_WIDTH - 1));
        row_last   = (row == RW'(IMAGE_HEIGHT - 1));
        lb_addr    = AW'(col >> 1);
        // A trailing even column of an odd-width row never gets a partner, so it is not held.
        hold_ld    = bus.valid_in && (state != ROW_SKIP) && !col[0]
                     && (int'(col) < 2 * POOL_W);
        lb_wr      = bus.valid_in && (state == ROW_EVEN) && col[0];
        out_fire   = bus.valid_in && (state == ROW_ODD) && col[0];
        frame_last = (int'(row) == 2 * POOL_H - 1) && (int'(col) == 2 * POOL_W - 1);
        pair_max   = pix_max(hold, bus.data_in);
        quad_max   = pix_max(lb_rd, pair_max);

        if (bus.valid_in) begin
            col_nxt = col_last ? '0 : col + CW'(1);
            if (col_last) begin
                row_nxt = row_last ? '0 : row + RW'(1);
                case (state)
                    ROW_EVEN: state_nxt = ROW_ODD;
                    ROW_ODD: begin
                        if (row_last)
                            state_nxt = ROW_EVEN;
                        else if (H_ODD && (row + RW'(1) == RW'(IMAGE_HEIGHT - 1)))
                            state_nxt = ROW_SKIP;
                        else
                            state_nxt = ROW_EVEN;
                    end
                    default: state_nxt = ROW_EVEN;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ROW_EVEN;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            row   <= row_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold          <= '0;
            bus.valid_out <= 1'b0;
            bus.data_out  <= '0;
        end else begin
            bus.valid_out <= out_fire;
            if (hold_ld) begin
                hold <= bus.data_in;
            end
            if (out_fire) begin
                bus.data_out <= quad_max;
            end
        end
    end

`ifdef MAXPOOL2_FRAME_DONE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= out_fire && frame_last;
        end
    end
`endif

    pool_line_buf #(
        .DEPTH     (POOL_W),
        .CHANNELS  (CHANNELS),
        .DATA_BITS (DATA_BITS),
        .AW        (AW)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (lb_wr),
        .wr_addr (lb_addr),
        .wr_data (pair_max),
        .rd_addr (lb_addr),
        .rd_data (lb_rd)
    );

endmodule

// File: tb/tb_maxpool2.sv
// Testbench for maxpool2: table-driven frame tests plus hand-written reset/latency sequences.
// Expected pooled values come from closed-form formulas of each input pattern.
// Define MAXPOOL2_FRAME_DONE_EN for both DUT and bench to check frame_done.
module tb_maxpool2;

    localparam int W = 13, H = 17, CH = 64, DB = 32, PW = 6, PH = 8, NOUT = 48;
    localparam int P_RAMP = 0, P_NEG = 1, P_DISC = 2, P_CHVAR = 3;

    typedef logic [0:CH-1][DB-1:0] pix_t;
    typedef struct {
        string name;
        int    pat;
        bit    gap;
        int    nframes;
        int    exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    maxpool2_if #(.CHANNELS(CH), .DATA_BITS(DB)) bus();

    maxpool2 #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .CHANNELS(CH), .DATA_BITS(DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_in = 0;
    int gap_viol = 0;
    int last_n_in = -1;
    pix_t out_q[$];
    bit   fd_q[$];
    int   cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.valid_out) begin
            if (n_in == last_n_in) gap_viol++;
            last_n_in = n_in;
            out_q.push_back(bus.data_out);
            cyc_q.push_back(cyc);
`ifdef MAXPOOL2_FRAME_DONE_EN
            fd_q.push_back(bus.frame_done);
`else
            fd_q.push_back(1'b0);
`endif
        end
    end

    function automatic logic [DB-1:0] pval(input int pat, input int c, input int r, input int ch);
        int v;
        v = r * 13 + c;
        case (pat)
            P_RAMP:  return DB'(v);
            P_NEG:   return (c == 0 && r == 0) ? -32'sd1 : -32'sd5;
            P_DISC:  return (c == 12 || r == 16) ? 32'h7FFF_FFFF : 32'h0;
            default: begin
                if (ch % 2 == 0) return DB'(v);
                return ((c + r) % 2 == 0) ? DB'(-(v + 1)) : DB'(v);
            end
        endcase
    endfunction

    function automatic logic [DB-1:0] expv(input int pat, input int i, input int j, input int ch);
        case (pat)
            P_RAMP:  return DB'((2 * j + 1) * 13 + 2 * i + 1);
            P_NEG:   return (i == 0 && j == 0) ? -32'sd1 : -32'sd5;
            P_DISC:  return 32'h0;
            default: return (ch % 2 == 0) ? DB'((2 * j + 1) * 13 + 2 * i + 1)
                                          : DB'((2 * j + 1) * 13 + 2 * i);
        endcase
    endfunction

    function automatic pix_t exp_pix(input int pat, input int i, input int j);
        pix_t p;
        for (int ch = 0; ch < CH; ch++) p[ch] = expv(pat, i, j, ch);
        return p;
    endfunction

    function automatic int first_diff(input pix_t a, input pix_t b);
        for (int ch = 0; ch < CH; ch++) if (a[ch] !== b[ch]) return ch;
        return 0;
    endfunction

    task automatic drive_px(input int pat, input int c, input int r, output int cap_cyc);
        bus.valid_in = 1'b1;
        for (int ch = 0; ch < CH; ch++) bus.data_in[ch] = pval(pat, c, r, ch);
        @(posedge clk);
        #1;
        cap_cyc = cyc;
        n_in++;
        bus.valid_in = 1'b0;
        bus.data_in  = {CH{32'($urandom())}};
    endtask

    task automatic run_frames(input int pat, input bit gap, input int nf, input int npix,
                              output int p11_cyc);
        int k, cc;
        k = 0;
        p11_cyc = -1;
        for (int f = 0; f < nf; f++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    if (npix < 0 || k < npix) begin
                        drive_px(pat, c, r, cc);
                        if (f == 0 && c == 1 && r == 1) p11_cyc = cc;
                        if (gap) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                    k++;
                end
    endtask

    task automatic check_outputs(input vec_t v, input int base);
        int got;
        pix_t e;
        got = out_q.size() - base;
        tests++;
        if (got != v.exp_cnt) begin
            fails++;
            $display("FAIL %s count: got %0d outputs, want %0d", v.name, got, v.exp_cnt);
        end
        for (int k = 0; k < got && k < v.exp_cnt; k++) begin
            int d;
            e = exp_pix(v.pat, k % PW, (k / PW) % PH);
            tests++;
            if (out_q[base + k] !== e) begin
                fails++;
                d = first_diff(out_q[base + k], e);
                $display("FAIL %s out%0d: got ch0=%h ch%0d=%h, want ch0=%h ch%0d=%h",
                         v.name, k, out_q[base + k][0], d, out_q[base + k][d], e[0], d, e[d]);
            end
`ifdef MAXPOOL2_FRAME_DONE_EN
            tests++;
            if (fd_q[base + k] !== ((k % NOUT) == NOUT - 1)) begin
                fails++;
                $display("FAIL %s frame_done out%0d: got %0b, want %0b",
                         v.name, k, fd_q[base + k], (k % NOUT) == NOUT - 1);
            end
`endif
        end
    endtask

    vec_t tbl[6];

    initial begin
        int base, gv0, p11;
        vec_t rv;
        pix_t e;

        tbl[0] = '{"ramp",      P_RAMP,  1'b0, 1, 48};
        tbl[1] = '{"negative",  P_NEG,   1'b0, 1, 48};
        tbl[2] = '{"valid_gap", P_RAMP,  1'b1, 1, 48};
        tbl[3] = '{"discard",   P_DISC,  1'b0, 1, 48};
        tbl[4] = '{"chan_sign", P_CHVAR, 1'b0, 1, 48};
        tbl[5] = '{"two_frame", P_RAMP,  1'b0, 2, 96};

        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (bus.valid_out !== 1'b0 || bus.data_out !== '0) begin
            fails++;
            $display("FAIL reset_state: got valid_out=%0b data_out[0]=%h, want 0 and 0",
                     bus.valid_out, bus.data_out[0]);
        end
`ifdef MAXPOOL2_FRAME_DONE_EN
        tests++;
        if (bus.frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_frame_done: got %0b, want 0", bus.frame_done);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int t = 0; t < 6; t++) begin
            base = out_q.size();
            gv0  = gap_viol;
            run_frames(tbl[t].pat, tbl[t].gap, tbl[t].nframes, -1, p11);
            repeat (4) @(posedge clk);
            #1;
            check_outputs(tbl[t], base);
            tests++;
            if (gap_viol != gv0) begin
                fails++;
                $display("FAIL %s back_to_back_valid_out: got %0d violations, want 0",
                         tbl[t].name, gap_viol - gv0);
            end
            if (t == 0) begin
                tests++;
                if (out_q.size() <= base || cyc_q[base] != p11) begin
                    fails++;
                    $display("FAIL latency: first output cycle %0d, want %0d",
                             (out_q.size() > base) ? cyc_q[base] : -1, p11);
                end
                // After idle cycles the last pooled pixel must still be on data_out.
                e = exp_pix(P_RAMP, PW - 1, PH - 1);
                tests++;
                if (bus.data_out !== e) begin
                    fails++;
                    $display("FAIL hold_data_out: got ch0=%h, want %h", bus.data_out[0], e[0]);
                end
            end
        end

        // Reset mid-frame after 40 pixels, then a full clean frame.
        run_frames(P_RAMP, 1'b0, 1, 40, p11);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.valid_out !== 1'b0 || bus.data_out !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got valid_out=%0b data_out[0]=%h, want 0 and 0",
                     bus.valid_out, bus.data_out[0]);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        base = out_q.size();
        rv = '{"after_reset", P_RAMP, 1'b0, 1, 48};
        run_frames(P_RAMP, 1'b0, 1, -1, p11);
        repeat (4) @(posedge clk);
        #1;
        check_outputs(rv, base);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
